// File: rtl/segfile_param.sv
// segfile_param: parametrised segment register file for the RrAg stage.
// Each entry holds a segment base, a segment limit, a pending flag and the
// producer tag (ptcid) of the instruction that will write it. Multiple
// write ports update base/limit/pending, a writeback bus clears pending
// entries whose tag matches, and read ports return the addressed entry,
// optionally bypassing same-cycle updates.
module segfile_param #(
  parameter int NUM_SEGS = 8,
  parameter int BASE_W   = 16,
  parameter int LIM_W    = 20,
  parameter int NUM_WR   = 4,
  parameter int NUM_RD   = 4,
  parameter int PTCID_W  = 7,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_SEGS)
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [NUM_WR*BASE_W-1:0]    base_in,
  input  logic [NUM_WR*LIM_W-1:0]     lim_in,
  input  logic [NUM_SEGS*LIM_W-1:0]   lim_inits,
  input  logic [NUM_WR*AW-1:0]        ld_addr,
  input  logic [NUM_WR-1:0]           ld_en,
  input  logic [NUM_WR-1:0]           lim_en,
  input  logic [NUM_WR-1:0]           dest,
  input  logic [PTCID_W-1:0]          new_ptcid,
  input  logic                        wb_en,
  input  logic [PTCID_W-1:0]          wb_ptcid,
  input  logic [NUM_RD*AW-1:0]        rd_addr,
  output logic [NUM_RD*BASE_W-1:0]    base_out,
  output logic [NUM_RD*LIM_W-1:0]     lim_out,
  output logic [NUM_RD-1:0]           pend_out,
  output logic [NUM_RD*PTCID_W-1:0]   ptc_out,
  output logic [AW:0]                 pend_cnt
);

  localparam bit BYP = (BYPASS != 0);

  // Registered entry state and its next-state image.
  logic [BASE_W-1:0]  base_q [NUM_SEGS];
  logic [BASE_W-1:0]  base_d [NUM_SEGS];
  logic [LIM_W-1:0]   lim_q  [NUM_SEGS];
  logic [LIM_W-1:0]   lim_d  [NUM_SEGS];
  logic [PTCID_W-1:0] tag_q  [NUM_SEGS];
  logic [PTCID_W-1:0] tag_d  [NUM_SEGS];
  logic [NUM_SEGS-1:0] pend_q;
  logic [NUM_SEGS-1:0] pend_d;
  logic [AW:0]         cnt_q;
  logic [AW:0]         cnt_d;

  // Per-entry decode of this cycle's write activity.
  logic [NUM_SEGS-1:0] set_hit;
  logic [NUM_SEGS-1:0] wb_hit;

  // Bypass only makes sense outside reset: while clr is high the outputs
  // must reflect the reset image, not the (ignored) incoming writes.
  logic use_byp;
  assign use_byp = BYP && !clr;

  // Base/limit next state: ports are scanned in ascending order so the
  // highest-index port hitting an entry overrides the lower ones.
  always_comb begin
    for (int e = 0; e < NUM_SEGS; e++) begin
      base_d[e] = base_q[e];
      lim_d[e]  = lim_q[e];
      for (int i = 0; i < NUM_WR; i++) begin
        if (ld_addr[i*AW +: AW] == AW'(e)) begin
          if (ld_en[i]) begin
            base_d[e] = base_in[i*BASE_W +: BASE_W];
          end
          if (lim_en[i]) begin
            lim_d[e] = lim_in[i*LIM_W +: LIM_W];
          end
        end
      end
    end
  end

  // Pending set decode: any dest port addressing the entry marks it.
  always_comb begin
    set_hit = '0;
    for (int e = 0; e < NUM_SEGS; e++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (dest[i] && (ld_addr[i*AW +: AW] == AW'(e))) begin
          set_hit[e] = 1'b1;
        end
      end
    end
  end

  // Writeback match: only entries still pending with an equal tag clear,
  // so a stale or foreign tag on the writeback bus is harmless.
  always_comb begin
    wb_hit = '0;
    for (int e = 0; e < NUM_SEGS; e++) begin
      wb_hit[e] = wb_en && pend_q[e] && (tag_q[e] == wb_ptcid);
    end
  end

  // Pending/tag next state: a new dest beats a simultaneous clear, and a
  // cleared entry keeps its last tag.
  always_comb begin
    pend_d = pend_q;
    for (int e = 0; e < NUM_SEGS; e++) begin
      tag_d[e] = tag_q[e];
      if (set_hit[e]) begin
        pend_d[e] = 1'b1;
        tag_d[e]  = new_ptcid;
      end else if (wb_hit[e]) begin
        pend_d[e] = 1'b0;
      end
    end
  end

  // Population count of the next pending vector, so the registered count
  // moves on the same edge as the bits it counts.
  always_comb begin
    cnt_d = '0;
    for (int e = 0; e < NUM_SEGS; e++) begin
      cnt_d = cnt_d + (AW+1)'(pend_d[e]);
    end
  end

  // Entry state register; reset clears everything and reloads the limits.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int e = 0; e < NUM_SEGS; e++) begin
        base_q[e] <= '0;
        lim_q[e]  <= lim_inits[e*LIM_W +: LIM_W];
        tag_q[e]  <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int e = 0; e < NUM_SEGS; e++) begin
        base_q[e] <= base_d[e];
        lim_q[e]  <= lim_d[e];
        tag_q[e]  <= tag_d[e];
      end
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  // Read ports: with bypass the next-state image already carries every
  // same-cycle write, dest and writeback clear with the right priorities.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[gi*AW +: AW];
      assign base_out[gi*BASE_W +: BASE_W]   = use_byp ? base_d[ra] : base_q[ra];
      assign lim_out[gi*LIM_W +: LIM_W]      = use_byp ? lim_d[ra]  : lim_q[ra];
      assign pend_out[gi]                    = use_byp ? pend_d[ra] : pend_q[ra];
      assign ptc_out[gi*PTCID_W +: PTCID_W]  = use_byp ? tag_d[ra]  : tag_q[ra];
    end
  endgenerate

endmodule

// File: tb/tb_segfile_param.sv
// tb_segfile_param: drives a bypassing and a non-bypassing instance with the
// same stimulus and checks both against an array-based model every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_segfile_param;
  localparam int NS = 8;
  localparam int BW = 16;
  localparam int LW = 20;
  localparam int NW = 4;
  localparam int NR = 4;
  localparam int PW = 7;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic clr;
  logic [NW*BW-1:0] base_in;
  logic [NW*LW-1:0] lim_in;
  logic [NS*LW-1:0] lim_inits;
  logic [NW*AW-1:0] ld_addr;
  logic [NW-1:0]    ld_en, lim_en, dest;
  logic [PW-1:0]    new_ptcid;
  logic             wb_en;
  logic [PW-1:0]    wb_ptcid;
  logic [NR*AW-1:0] rd_addr;

  logic [NR*BW-1:0] base_out1, base_out0;
  logic [NR*LW-1:0] lim_out1, lim_out0;
  logic [NR-1:0]    pend_out1, pend_out0;
  logic [NR*PW-1:0] ptc_out1, ptc_out0;
  logic [AW:0]      pend_cnt1, pend_cnt0;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  segfile_param #(.NUM_SEGS(NS), .BASE_W(BW), .LIM_W(LW), .NUM_WR(NW), .NUM_RD(NR),
                  .PTCID_W(PW), .BYPASS(1)) dut1 (
    .clk(clk), .clr(clr), .base_in(base_in), .lim_in(lim_in), .lim_inits(lim_inits),
    .ld_addr(ld_addr), .ld_en(ld_en), .lim_en(lim_en), .dest(dest), .new_ptcid(new_ptcid),
    .wb_en(wb_en), .wb_ptcid(wb_ptcid), .rd_addr(rd_addr), .base_out(base_out1),
    .lim_out(lim_out1), .pend_out(pend_out1), .ptc_out(ptc_out1), .pend_cnt(pend_cnt1));

  segfile_param #(.NUM_SEGS(NS), .BASE_W(BW), .LIM_W(LW), .NUM_WR(NW), .NUM_RD(NR),
                  .PTCID_W(PW), .BYPASS(0)) dut0 (
    .clk(clk), .clr(clr), .base_in(base_in), .lim_in(lim_in), .lim_inits(lim_inits),
    .ld_addr(ld_addr), .ld_en(ld_en), .lim_en(lim_en), .dest(dest), .new_ptcid(new_ptcid),
    .wb_en(wb_en), .wb_ptcid(wb_ptcid), .rd_addr(rd_addr), .base_out(base_out0),
    .lim_out(lim_out0), .pend_out(pend_out0), .ptc_out(ptc_out0), .pend_cnt(pend_cnt0));

  // Reference model: current contents (m_*) and contents after this cycle's edge (n_*).
  logic [BW-1:0] m_base [NS];
  logic [LW-1:0] m_lim  [NS];
  logic          m_pend [NS];
  logic [PW-1:0] m_tag  [NS];
  logic [BW-1:0] n_base [NS];
  logic [LW-1:0] n_lim  [NS];
  logic          n_pend [NS];
  logic [PW-1:0] n_tag  [NS];

  task automatic chk(input string name, input int port, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s port=%0d got=%h exp=%h t=%0t", name, port, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < NS; e++) begin
      m_base[e] = '0;
      m_lim[e]  = lim_inits[e*LW +: LW];
      m_pend[e] = 1'b0;
      m_tag[e]  = '0;
    end
  endtask

  // Apply the update rules in plain order: writeback clears first, then the
  // writes port by port (later port overwrites), dest last so it wins.
  task automatic calc_next();
    for (int e = 0; e < NS; e++) begin
      n_base[e] = m_base[e];
      n_lim[e]  = m_lim[e];
      n_pend[e] = m_pend[e];
      n_tag[e]  = m_tag[e];
      if (wb_en && m_pend[e] && m_tag[e] == wb_ptcid) n_pend[e] = 1'b0;
    end
    for (int i = 0; i < NW; i++) begin
      int a;
      a = int'(ld_addr[i*AW +: AW]);
      if (ld_en[i])  n_base[a] = base_in[i*BW +: BW];
      if (lim_en[i]) n_lim[a]  = lim_in[i*LW +: LW];
      if (dest[i]) begin
        n_pend[a] = 1'b1;
        n_tag[a]  = new_ptcid;
      end
    end
  endtask

  // Model state advance on the clock; async reset tracked separately.
  always @(posedge clk) begin
    if (clr) model_reset();
    else begin
      calc_next();
      for (int e = 0; e < NS; e++) begin
        m_base[e] = n_base[e];
        m_lim[e]  = n_lim[e];
        m_pend[e] = n_pend[e];
        m_tag[e]  = n_tag[e];
      end
    end
  end

  always @(posedge clr) model_reset();

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int cnt;
      calc_next();
      cnt = 0;
      for (int e = 0; e < NS; e++) cnt += int'(m_pend[e]);
      chk("cnt_byp", 0, 32'(pend_cnt1), cnt);
      chk("cnt_reg", 0, 32'(pend_cnt0), cnt);
      for (int j = 0; j < NR; j++) begin
        int a;
        a = int'(rd_addr[j*AW +: AW]);
        chk("base_reg", j, 32'(base_out0[j*BW +: BW]), 32'(m_base[a]));
        chk("lim_reg",  j, 32'(lim_out0[j*LW +: LW]),  32'(m_lim[a]));
        chk("pend_reg", j, 32'(pend_out0[j]),          32'(m_pend[a]));
        chk("ptc_reg",  j, 32'(ptc_out0[j*PW +: PW]),  32'(m_tag[a]));
        if (clr) begin
          chk("base_byp", j, 32'(base_out1[j*BW +: BW]), 32'(m_base[a]));
          chk("lim_byp",  j, 32'(lim_out1[j*LW +: LW]),  32'(m_lim[a]));
          chk("pend_byp", j, 32'(pend_out1[j]),          32'(m_pend[a]));
          chk("ptc_byp",  j, 32'(ptc_out1[j*PW +: PW]),  32'(m_tag[a]));
        end else begin
          chk("base_byp", j, 32'(base_out1[j*BW +: BW]), 32'(n_base[a]));
          chk("lim_byp",  j, 32'(lim_out1[j*LW +: LW]),  32'(n_lim[a]));
          chk("pend_byp", j, 32'(pend_out1[j]),          32'(n_pend[a]));
          chk("ptc_byp",  j, 32'(ptc_out1[j*PW +: PW]),  32'(n_tag[a]));
        end
      end
    end
  end

  task automatic set_idle();
    base_in = '0; lim_in = '0; ld_addr = '0;
    ld_en = '0; lim_en = '0; dest = '0;
    new_ptcid = '0; wb_en = 1'b0; wb_ptcid = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    set_idle();
    for (int k = 0; k < NS; k++) lim_inits[k*LW +: LW] = LW'(32'h100 * (k + 1));
    for (int j = 0; j < NR; j++) rd_addr[j*AW +: AW] = AW'(j);
    clr = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1;

    // Reset image
    $display("phase reset");
    #1;
    for (int j = 0; j < NR; j++) begin
      chk("rst_lim", j, 32'(lim_out1[j*LW +: LW]), 32'h100 * (j + 1));
      chk("rst_lim0", j, 32'(lim_out0[j*LW +: LW]), 32'h100 * (j + 1));
      chk("rst_base", j, 32'(base_out1[j*BW +: BW]), 32'h0);
    end
    chk("rst_cnt", 0, 32'(pend_cnt1), 32'h0);
    // Writes during reset must be ignored, including on the bypass path
    for (int i = 0; i < NW; i++) begin
      ld_addr[i*AW +: AW] = AW'(i);
      base_in[i*BW +: BW] = 16'hFFFF;
    end
    ld_en = '1; lim_en = '1; dest = '1;
    tick();
    @(posedge clk);
    #1;
    chk("rst_hold_base", 0, 32'(base_out1[0 +: BW]), 32'h0);
    chk("rst_hold_lim", 0, 32'(lim_out1[0 +: LW]), 32'h100);
    chk("rst_hold_cnt", 0, 32'(pend_cnt1), 32'h0);
    set_idle();
    #1 clr = 1'b0;

    // Parallel load, two batches, bypass visible in the write cycle
    $display("phase parallel_load");
    for (int b = 0; b < 2; b++) begin
      tick();
      for (int i = 0; i < NW; i++) begin
        ld_addr[i*AW +: AW] = AW'(4*b + i);
        base_in[i*BW +: BW] = BW'(32'h1111 * (4*b + i));
        rd_addr[i*AW +: AW] = AW'(4*b + i);
      end
      ld_en = '1;
      #1;
      for (int j = 0; j < NR; j++) begin
        chk("load_byp", j, 32'(base_out1[j*BW +: BW]), 32'h1111 * (4*b + j));
        chk("load_lag", j, 32'(base_out0[j*BW +: BW]), 32'h0);
      end
    end
    tick();
    set_idle();
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < NR; j++) rd_addr[j*AW +: AW] = AW'(4*b + j);
      #1;
      for (int j = 0; j < NR; j++)
        chk("load_rd", j, 32'(base_out0[j*BW +: BW]), 32'h1111 * (4*b + j));
    end

    // Write conflict and limit write
    $display("phase conflict");
    tick();
    ld_addr[0 +: AW] = 3'd5; base_in[0 +: BW] = 16'hAAAA;
    ld_addr[3*AW +: AW] = 3'd5; base_in[3*BW +: BW] = 16'hBBBB;
    ld_en = 4'b1001;
    ld_addr[1*AW +: AW] = 3'd2; lim_in[1*LW +: LW] = 20'h12345; lim_en = 4'b0010;
    tick();
    set_idle();
    rd_addr[0 +: AW] = 3'd5; rd_addr[1*AW +: AW] = 3'd2;
    #1;
    chk("conflict_base", 0, 32'(base_out0[0 +: BW]), 32'hBBBB);
    chk("lim_write", 1, 32'(lim_out0[1*LW +: LW]), 32'h12345);

    // Pending set, tag-matched clear, unmatched writeback
    $display("phase pending");
    tick();
    ld_addr[0 +: AW] = 3'd1; ld_addr[1*AW +: AW] = 3'd2; dest = 4'b0011; new_ptcid = 7'h2A;
    tick();
    set_idle();
    rd_addr[0 +: AW] = 3'd1; rd_addr[1*AW +: AW] = 3'd2;
    #1;
    chk("pend_cnt2", 0, 32'(pend_cnt0), 32'd2);
    chk("pend_tag", 0, 32'(ptc_out0[0 +: PW]), 32'h2A);
    chk("pend_tag", 1, 32'(ptc_out0[1*PW +: PW]), 32'h2A);
    tick();
    wb_en = 1'b1; wb_ptcid = 7'h2A;
    #1;
    chk("wb_byp_pend", 0, 32'(pend_out1[0]), 32'h0);
    tick();
    set_idle();
    #1;
    chk("wb_cnt", 0, 32'(pend_cnt0), 32'd0);
    chk("wb_tag_kept", 1, 32'(ptc_out0[1*PW +: PW]), 32'h2A);
    tick();
    wb_en = 1'b1; wb_ptcid = 7'h11;
    tick();
    set_idle();
    #1;
    chk("wb_nomatch_cnt", 0, 32'(pend_cnt0), 32'd0);

    // Set and clear on the same entry in one cycle
    $display("phase collision");
    tick();
    ld_addr[0 +: AW] = 3'd3; dest = 4'b0001; new_ptcid = 7'h05;
    rd_addr[0 +: AW] = 3'd3;
    tick();
    set_idle();
    #1;
    chk("coll_pre_cnt", 0, 32'(pend_cnt0), 32'd1);
    tick();
    ld_addr[0 +: AW] = 3'd3; dest = 4'b0001; new_ptcid = 7'h06; wb_en = 1'b1; wb_ptcid = 7'h05;
    tick();
    set_idle();
    #1;
    chk("coll_pend", 0, 32'(pend_out0[0]), 32'h1);
    chk("coll_tag", 0, 32'(ptc_out0[0 +: PW]), 32'h06);
    chk("coll_cnt", 0, 32'(pend_cnt0), 32'd1);

    // Asynchronous reset with six entries pending
    $display("phase midop_reset");
    tick();
    ld_addr = {3'd4, 3'd2, 3'd1, 3'd0}; dest = 4'b1111; new_ptcid = 7'h10;
    tick();
    set_idle();
    ld_addr[0 +: AW] = 3'd5; dest = 4'b0001; new_ptcid = 7'h10;
    tick();
    set_idle();
    rd_addr = {3'd4, 3'd2, 3'd1, 3'd5};
    #1;
    chk("mid_cnt6", 0, 32'(pend_cnt0), 32'd6);
    chk("mid_pend", 0, 32'(pend_out0), 32'hF);
    #1 clr = 1'b1;
    #1;
    chk("mid_rst_cnt", 0, 32'(pend_cnt0), 32'd0);
    chk("mid_rst_cnt_byp", 0, 32'(pend_cnt1), 32'd0);
    chk("mid_rst_pend", 0, 32'(pend_out1), 32'h0);
    chk("mid_rst_base", 0, 32'(base_out0[0 +: BW]), 32'h0);
    chk("mid_rst_lim", 0, 32'(lim_out0[0 +: LW]), 32'h600);
    chk("mid_rst_lim2", 2, 32'(lim_out1[2*LW +: LW]), 32'h300);
    tick();
    clr = 1'b0;

    // Randomised traffic with occasional asynchronous reset pulses
    $display("phase random");
    for (int c = 0; c < 1500; c++) begin
      tick();
      clr = 1'b0;
      for (int i = 0; i < NW; i++) begin
        ld_addr[i*AW +: AW] = AW'($urandom_range(0, NS - 1));
        base_in[i*BW +: BW] = BW'($urandom);
        lim_in[i*LW +: LW]  = LW'($urandom);
      end
      for (int j = 0; j < NR; j++) rd_addr[j*AW +: AW] = AW'($urandom_range(0, NS - 1));
      ld_en  = NW'($urandom & $urandom);
      lim_en = NW'($urandom & $urandom);
      dest   = NW'($urandom & $urandom & $urandom);
      new_ptcid = PW'($urandom_range(0, 3));
      wb_en = 1'($urandom_range(0, 1));
      wb_ptcid = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) #1 clr = 1'b1;
    end
    tick();
    clr = 1'b0;
    set_idle();
    tick();
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/segfile_param.md
Name: segfile_param

Overview:
- Parametrised successor to the fixed 8-entry, 4-port segment register file.
- Holds per-segment base, limit, pending flag and producer tag (ptcid).
- Adds generic port counts, a limit write path, writeback-driven pending clear with tag match, optional write-to-read bypass, and a pending-entry counter.
- Sits in the RrAg stage and feeds segment base/limit and dependency state to address generation.

Parameters:
NUM_SEGS, 8, number of segment entries; must be a power of two, at most 16
BASE_W, 16, base field width
LIM_W, 20, limit field width
NUM_WR, 4, number of load/write ports
NUM_RD, 4, number of read ports
PTCID_W, 7, producer tag width
BYPASS, 1, 1 = a same-cycle write is visible on the read outputs; 0 = reads show registered state only
AW, log2(NUM_SEGS), derived address width

Ports:
clk  in  1  clock; all state updates on the rising edge
clr  in  1  asynchronous active-high reset
base_in  in  NUM_WR*BASE_W  write data; port i occupies slice i
lim_in  in  NUM_WR*LIM_W  limit write data
lim_inits  in  NUM_SEGS*LIM_W  limit values loaded while clr is high
ld_addr  in  NUM_WR*AW  write address per port
ld_en  in  NUM_WR  base write enable per port
lim_en  in  NUM_WR  limit write enable per port
dest  in  NUM_WR  mark the addressed entry pending with new_ptcid
new_ptcid  in  PTCID_W  tag written by any asserted dest
wb_en  in  1  writeback valid
wb_ptcid  in  PTCID_W  writeback tag
rd_addr  in  NUM_RD*AW  read address per port
base_out  out  NUM_RD*BASE_W  base of the addressed entry
lim_out  out  NUM_RD*LIM_W  limit of the addressed entry
pend_out  out  NUM_RD  pending flag of the addressed entry
ptc_out  out  NUM_RD*PTCID_W  tag of the addressed entry
pend_cnt  out  AW+1  number of entries currently pending

Behaviour:
Reset (clr=1, asynchronous, held as long as clr is high):
- base = 0, pending = 0, tag = 0, limit[k] = lim_inits slice k.
- Outputs follow the combinational read of that state: base_out 0, pend_out 0, ptc_out 0, lim_out = lim_inits of the addressed entries, pend_cnt 0.
- On clr deassertion, the first active edge is the next posedge; no updates occur while clr is high.

Writes, on posedge with clr=0:
- ld_en[i]: base[ld_addr[i]] <= base_in[i].
- lim_en[i]: limit[ld_addr[i]] <= lim_in[i].
- The ld_en, lim_en and dest enables of a port are independent.
- Several ports hitting the same entry with the same field type: the highest-index port wins.

Pending/tag tracking:
- dest[i]: pending[ld_addr[i]] <= 1, tag <= new_ptcid.
- wb_en: every entry with pending=1 and tag == wb_ptcid has pending cleared; its tag is retained.
- Set and clear on the same entry in the same cycle: the set wins, and the tag becomes new_ptcid.
- Multiple entries may share a tag; a single wb clears all of them.
- A wb with no match is a no-op.

Reads: combinational.
- BYPASS=1: a read address equal to an active write address returns the incoming value for each field (base, limit, pending=1/tag from dest). The highest-index write port has priority.
- BYPASS=1: a wb match on a non-dest entry shows pend_out=0 in the same cycle.
- BYPASS=0: reads return registered contents only; a write is visible the cycle after the edge.

pend_cnt:
- Registered population count of the pending bits, updated on the same edge as those bits.
- Range 0..NUM_SEGS; it cannot overflow because its width is AW+1.

Out-of-range addresses: not possible, because NUM_SEGS is a power of two.

Test Plan:
- Reset: clr=1, lim_inits entry k = 0x00100*(k+1) -> lim_out port j with rd_addr=j shows 0x00100*(j+1); base_out=0; pend_cnt=0. Toggle ld_en during clr -> no state change.
- Parallel load: 4 ports write base 0x0000/0x1111/0x2222/0x3333 to entries 0..3, then 0x4444..0x7777 to entries 4..7 -> reading entries 0..7 returns the matching pattern. Also, with BYPASS=1, each value is visible in its write cycle.
- Write conflict: ports 0 and 3 both write entry 5 with 0xAAAA/0xBBBB -> base[5]=0xBBBB. A lim_en write of 0x12345 to entry 2 -> lim_out=0x12345 next cycle.
- Pending: dest to entries 1,2 with new_ptcid=0x2A -> pend_cnt 2, ptc_out=0x2A. Then wb_en with 0x2A -> both cleared, pend_cnt 0, tag still 0x2A. Then wb with 0x11 -> no change.
- Collision: entry 3 pending with tag 0x05; same cycle wb_ptcid=0x05 and dest to entry 3 with new_ptcid=0x06 -> pending=1, tag=0x06, pend_cnt unchanged.
- Mid-operation reset: assert clr asynchronously between edges with 6 entries pending -> pend_cnt and pend_out drop to 0 immediately; base=0; limits reload from lim_inits.
- BYPASS=0 build: rerun the parallel-load test -> base_out lags the write by one cycle.
